// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: operation modes and burst FSM states.
package usr_pkg;

  // Low two bits keep the legacy S1,S0 meaning (HOLD/SHR/SHL/LOAD).
  typedef enum logic [2:0] {
    HOLD  = 3'b000,
    SHR   = 3'b001,
    SHL   = 3'b010,
    LOAD  = 3'b011,
    ROTR  = 3'b100,
    ROTL  = 3'b101,
    ASHR  = 3'b110,
    CLEAR = 3'b111
  } usr_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } usr_state_e;

endpackage

// File: rtl/usr_next_value.sv
// Combinational next-value generator: one operation of the selected mode applied to q.
// Shared by the single-step path and the burst path.
module usr_next_value
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  usr_mode_e        mode,
  input  logic             si_r,
  input  logic             si_l,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] nxt
);

  // Upper WIDTH-1 bits moved one place down; SHR, ROTR and ASHR differ only in the new MSB.
  logic [WIDTH-2:0] down;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_down
      assign down[gi] = q[gi+1];
    end
  endgenerate

  // Select the operation result for the requested mode.
  always_comb begin
    nxt = q;
    unique case (mode)
      HOLD:    nxt = q;
      SHR:     nxt = {si_r, down};
      SHL:     nxt = {q[WIDTH-2:0], si_l};
      LOAD:    nxt = pin;
      ROTR:    nxt = {q[0], down};
      ROTL:    nxt = {q[WIDTH-2:0], q[WIDTH-1]};
      ASHR:    nxt = {q[WIDTH-1], down};
      CLEAR:   nxt = '0;
      default: nxt = q;
    endcase
  end

endmodule

// File: rtl/uni_shiftregister_n.sv
// WIDTH-bit universal shift register with single-step operation and a burst engine
// that repeats one latched operation for a programmed number of cycles.
module uni_shiftregister_n
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(WIDTH) + 1
) (
  input  logic             CLK,
  input  logic             RES,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             si_r,
  input  logic             si_l,
  input  logic [WIDTH-1:0] pin,
  input  logic             start,
  input  logic [AW-1:0]    amt,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             so_r,
  output logic             so_l,
  output logic             busy,
  output logic             done
);

  localparam logic [AW-1:0] MAX_AMT = AW'(WIDTH);

  usr_state_e       state_reg, state_next;
  usr_mode_e        bmode_reg, bmode_next;
  logic [AW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] q_reg, q_next;

  usr_mode_e        op_mode;
  logic [WIDTH-1:0] step_value;
  logic [AW-1:0]    amt_clamped;

  // Bursts longer than the register width are pointless, so they saturate at WIDTH.
  assign amt_clamped = (amt > MAX_AMT) ? MAX_AMT : amt;

  // While a burst runs the latched mode drives the datapath; live mode is ignored.
  assign op_mode = (state_reg == RUN) ? bmode_reg : usr_mode_e'(mode);

  usr_next_value #(
    .WIDTH (WIDTH)
  ) u_next (
    .q    (q_reg),
    .mode (op_mode),
    .si_r (si_r),
    .si_l (si_l),
    .pin  (pin),
    .nxt  (step_value)
  );

  // State, burst count, latched mode and data register.
  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      state_reg <= IDLE;
      bmode_reg <= HOLD;
      cnt_reg   <= '0;
      q_reg     <= '0;
    end else begin
      state_reg <= state_next;
      bmode_reg <= bmode_next;
      cnt_reg   <= cnt_next;
      q_reg     <= q_next;
    end
  end

  // Next-state logic: start beats en in IDLE, abort beats the op in RUN, DONE lasts one cycle.
  always_comb begin
    state_next = state_reg;
    bmode_next = bmode_reg;
    cnt_next   = cnt_reg;
    q_next     = q_reg;
    unique case (state_reg)
      IDLE: begin
        if (start) begin
          if (amt_clamped != '0) begin
            bmode_next = usr_mode_e'(mode);
            cnt_next   = amt_clamped;
            state_next = RUN;
          end else begin
            state_next = DONE;
          end
        end else if (en) begin
          q_next = step_value;
        end
      end
      RUN: begin
        if (abort) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          q_next   = step_value;
          cnt_next = cnt_reg - 1'b1;
          if (cnt_reg == AW'(1)) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign q    = q_reg;
  assign so_r = q_reg[0];
  assign so_l = q_reg[WIDTH-1];
  assign busy = (state_reg != IDLE);
  assign done = (state_reg == DONE);

endmodule

// File: tb/tb_uni_shiftregister_n.sv
// Directed bench for uni_shiftregister_n (WIDTH=8) with a cycle-stamped scoreboard.
module tb_uni_shiftregister_n;

  localparam int W  = 8;
  localparam int AW = 4;

  localparam logic [2:0] M_HOLD  = 3'b000;
  localparam logic [2:0] M_SHR   = 3'b001;
  localparam logic [2:0] M_SHL   = 3'b010;
  localparam logic [2:0] M_LOAD  = 3'b011;
  localparam logic [2:0] M_ROTR  = 3'b100;
  localparam logic [2:0] M_ROTL  = 3'b101;
  localparam logic [2:0] M_ASHR  = 3'b110;
  localparam logic [2:0] M_CLEAR = 3'b111;

  logic          CLK = 1'b0;
  logic          RES = 1'b1;
  logic          en = 1'b0;
  logic [2:0]    mode = 3'b000;
  logic          si_r = 1'b0;
  logic          si_l = 1'b0;
  logic [W-1:0]  pin = '0;
  logic          start = 1'b0;
  logic [AW-1:0] amt = '0;
  logic          abort = 1'b0;
  logic [W-1:0]  q;
  logic          so_r, so_l, busy, done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int          cyc;
    string       name;
    logic [W-1:0] q;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t sb[$];

  uni_shiftregister_n #(.WIDTH(W), .AW(AW)) dut (
    .CLK   (CLK),
    .RES   (RES),
    .en    (en),
    .mode  (mode),
    .si_r  (si_r),
    .si_l  (si_l),
    .pin   (pin),
    .start (start),
    .amt   (amt),
    .abort (abort),
    .q     (q),
    .so_r  (so_r),
    .so_l  (so_l),
    .busy  (busy),
    .done  (done)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic compare(input string name, input logic [W-1:0] eq, input logic eb, input logic ed);
    logic [W+3:0] got, req;
    got = {q, so_l, so_r, busy, done};
    req = {eq, eq[W-1], eq[0], eb, ed};
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got q=%h so_l=%b so_r=%b busy=%b done=%b required q=%h so_l=%b so_r=%b busy=%b done=%b",
               name, q, so_l, so_r, busy, done, eq, eq[W-1], eq[0], eb, ed);
    end else begin
      $display("ok   %s q=%h busy=%b done=%b", name, q, busy, done);
    end
  endtask

  // Monitor: pops every expectation stamped for the current cycle and compares.
  always @(negedge CLK) begin : monitor
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s missed: stamp %0d required, now at %0d", e.name, e.cyc, cyc);
      end else begin
        compare(e.name, e.q, e.busy, e.done);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic expect_at(input int c, input string n, input logic [W-1:0] eq, input logic eb, input logic ed);
    sb.push_back('{cyc: c, name: n, q: eq, busy: eb, done: ed});
  endtask

  task automatic load(input logic [W-1:0] v, input string n);
    en = 1'b1;
    mode = M_LOAD;
    pin = v;
    expect_at(cyc + 1, n, v, 1'b0, 1'b0);
    step();
    en = 1'b0;
    mode = M_HOLD;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int k;
    #1 RES = 1'b0;
    #1 compare("reset_async", 8'h00, 1'b0, 1'b0);
    #10 RES = 1'b1;
    step();
    expect_at(cyc, "reset_state", 8'h00, 1'b0, 1'b0);

    // 1: single-step LOAD, SHR, SHL, then hold with en=0
    en = 1'b1; mode = M_LOAD; pin = 8'hA5;
    expect_at(cyc + 1, "t1_load", 8'hA5, 1'b0, 1'b0);
    step();
    mode = M_SHR; si_r = 1'b0;
    expect_at(cyc + 1, "t1_shr", 8'h52, 1'b0, 1'b0);
    step();
    mode = M_SHL; si_l = 1'b1;
    expect_at(cyc + 1, "t1_shl", 8'hA5, 1'b0, 1'b0);
    step();
    en = 1'b0; mode = M_HOLD;
    expect_at(cyc + 1, "t1_hold", 8'hA5, 1'b0, 1'b0);
    step();

    // 2: ROTL burst of 3 from 81
    load(8'h81, "t2_load");
    start = 1'b1; mode = M_ROTL; amt = 4'd3;
    k = cyc + 1;
    expect_at(k,     "t2_start", 8'h81, 1'b1, 1'b0);
    expect_at(k + 1, "t2_op1",   8'h03, 1'b1, 1'b0);
    expect_at(k + 2, "t2_op2",   8'h06, 1'b1, 1'b0);
    expect_at(k + 3, "t2_op3",   8'h0C, 1'b1, 1'b1);
    expect_at(k + 4, "t2_idle",  8'h0C, 1'b0, 1'b0);
    step();
    start = 1'b0; mode = M_HOLD;
    idle(4);

    // 3: ASHR burst of 2 from 90, live mode/en changed to CLEAR meanwhile
    load(8'h90, "t3_load");
    start = 1'b1; mode = M_ASHR; amt = 4'd2;
    k = cyc + 1;
    expect_at(k,     "t3_start", 8'h90, 1'b1, 1'b0);
    expect_at(k + 1, "t3_op1",   8'hC8, 1'b1, 1'b0);
    expect_at(k + 2, "t3_op2",   8'hE4, 1'b1, 1'b1);
    expect_at(k + 3, "t3_idle",  8'hE4, 1'b0, 1'b0);
    step();
    start = 1'b0; mode = M_CLEAR; en = 1'b1;
    idle(2);
    en = 1'b0; mode = M_HOLD;
    step();

    // 4a: amt=0 gives a one-cycle busy/done with q untouched
    start = 1'b1; mode = M_SHR; amt = 4'd0;
    k = cyc + 1;
    expect_at(k,     "t4a_done", 8'hE4, 1'b1, 1'b1);
    expect_at(k + 1, "t4a_idle", 8'hE4, 1'b0, 1'b0);
    step();
    start = 1'b0; mode = M_HOLD;
    step();

    // 4b: amt=15 clamps to 8 SHL ops shifting in ones
    en = 1'b1; mode = M_CLEAR;
    expect_at(cyc + 1, "t4b_clear", 8'h00, 1'b0, 1'b0);
    step();
    en = 1'b0;
    start = 1'b1; mode = M_SHL; si_l = 1'b1; amt = 4'd15;
    k = cyc + 1;
    expect_at(k, "t4b_start", 8'h00, 1'b1, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      logic [W-1:0] v;
      v = W'((1 << i) - 1);
      expect_at(k + i, $sformatf("t4b_op%0d", i), v, 1'b1, (i == 8));
    end
    expect_at(k + 9, "t4b_idle", 8'hFF, 1'b0, 1'b0);
    step();
    start = 1'b0; mode = M_HOLD;
    idle(9);

    // 4c: start held through a burst is re-accepted once busy falls
    start = 1'b1; mode = M_SHR; si_r = 1'b0; amt = 4'd2;
    k = cyc + 1;
    expect_at(k,     "t4c_start",  8'hFF, 1'b1, 1'b0);
    expect_at(k + 1, "t4c_op1",    8'h7F, 1'b1, 1'b0);
    expect_at(k + 2, "t4c_op2",    8'h3F, 1'b1, 1'b1);
    expect_at(k + 3, "t4c_gap",    8'h3F, 1'b0, 1'b0);
    expect_at(k + 4, "t4c_restart",8'h3F, 1'b1, 1'b0);
    expect_at(k + 5, "t4c_op3",    8'h1F, 1'b1, 1'b0);
    expect_at(k + 6, "t4c_op4",    8'h0F, 1'b1, 1'b1);
    expect_at(k + 7, "t4c_idle",   8'h0F, 1'b0, 1'b0);
    step();
    idle(4);
    start = 1'b0; mode = M_HOLD;
    idle(3);

    // 5: SHR burst of 5 aborted on the third RUN edge
    load(8'hB6, "t5_load");
    start = 1'b1; mode = M_SHR; si_r = 1'b1; amt = 4'd5;
    k = cyc + 1;
    expect_at(k,     "t5_start", 8'hB6, 1'b1, 1'b0);
    expect_at(k + 1, "t5_op1",   8'hDB, 1'b1, 1'b0);
    expect_at(k + 2, "t5_op2",   8'hED, 1'b1, 1'b0);
    expect_at(k + 3, "t5_abort", 8'hED, 1'b0, 1'b0);
    expect_at(k + 4, "t5_after", 8'hED, 1'b0, 1'b0);
    step();
    start = 1'b0; mode = M_HOLD;
    idle(2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();

    // 6: asynchronous reset in the middle of a ROTR burst, then a fresh LOAD
    start = 1'b1; mode = M_ROTR; amt = 4'd4;
    k = cyc + 1;
    expect_at(k,     "t6_start", 8'hED, 1'b1, 1'b0);
    expect_at(k + 1, "t6_op1",   8'hF6, 1'b1, 1'b0);
    step();
    start = 1'b0; mode = M_HOLD;
    step();
    #5 RES = 1'b0;
    #1 compare("t6_reset_async", 8'h00, 1'b0, 1'b0);
    #9 RES = 1'b1;
    step();
    expect_at(cyc, "t6_after_reset", 8'h00, 1'b0, 1'b0);
    en = 1'b1; mode = M_LOAD; pin = 8'h3C;
    expect_at(cyc + 1, "t6_load", 8'h3C, 1'b0, 1'b0);
    step();
    en = 1'b0; mode = M_HOLD;
    expect_at(cyc + 1, "t6_hold", 8'h3C, 1'b0, 1'b0);
    step();

    idle(2);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain got %0d pending required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uni_shiftregister_n.md
# uni_shiftregister_n

Parametrised universal shift register: the WIDTH-bit successor to the 4-bit universal shift register. It adds rotate, arithmetic-shift and clear modes, separate left/right serial inputs and serial outputs, and a burst engine that repeats one operation a programmed number of cycles with busy/done handshake. It sits in the datapath library as the general serial/parallel conversion and shifting element.

## Interface
- WIDTH, 8, register width in bits; legal range 2 to 64.
- AW, $clog2(WIDTH)+1, width of burst count; must represent 0..WIDTH.

- CLK  in  1  clock; all state changes on the rising edge.
- RES  in  1  reset, asynchronous, active-low.
- en  in  1  single-step enable; honoured only when busy=0 and start=0.
- mode  in  3  operation select, encodings under Operation.
- si_r  in  1  serial input entering the MSB on SHR.
- si_l  in  1  serial input entering the LSB on SHL.
- pin  in  WIDTH  parallel load data.
- start  in  1  begin burst; sampled only when busy=0.
- amt  in  AW  burst length in cycles, 0..WIDTH; values above WIDTH are clamped to WIDTH.
- abort  in  1  terminate a running burst.
- q  out  WIDTH  register contents.
- so_r  out  1  q[0].
- so_l  out  1  q[WIDTH-1].
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse at burst completion.

## Operation
- mode encodings, where the low two bits match the legacy S1,S0 encoding:
  - 000 HOLD
  - 001 SHR: q <= {si_r, q[W-1:1]}
  - 010 SHL: q <= {q[W-2:0], si_l}
  - 011 LOAD: q <= pin
  - 100 ROTR
  - 101 ROTL
  - 110 ASHR: MSB replicated
  - 111 CLEAR: q <= 0
- Single step: with busy=0, start=0 and en=1, one op of the current mode is applied at the edge. With en=0, q holds.
- Burst FSM states are IDLE, RUN and DONE.
  - IDLE, start=1, clamped amt≥1: latch mode into bmode and amt into cnt, then go to RUN. No op is applied on the start edge.
  - IDLE, start=1, amt=0: go to DONE; q is unchanged.
  - RUN, each edge: apply bmode once and decrement cnt. When cnt was 1, go to DONE.
  - RUN, abort=1: no op is applied; go to IDLE, and done is not pulsed. abort has priority over the op.
  - DONE: go to IDLE after one cycle.
- During a burst, si_r, si_l and pin are sampled live on every edge. mode, amt, en and start are ignored while busy=1.
- start has priority over en in the same cycle; the single step is dropped.
- start and abort are both ignored in DONE.

## Timing
- Reset values: q=0, so_r=0, so_l=0, busy=0, done=0, state=IDLE, cnt=0. All take effect immediately on RES falling, with no clock required.
- Reset during RUN: the burst is lost. After release the block is in IDLE with no done pulse.
- Single-step latency: q updates at the first rising edge where en=1 is sampled.
- Burst with start sampled at edge k and amt=N≥1:
  - ops occur at edges k+1..k+N;
  - done=1 for the cycle between edges k+N and k+N+1;
  - busy=1 from edge k to edge k+N+1, which is N+1 cycles.
- Burst with amt=0: busy=done=1 for exactly the one cycle after edge k.
- A new start is accepted back-to-back at the first edge where busy=0.
- All outputs are registered or direct register taps; there is no combinational path from input to output.

## Structure
- Shared package usr_pkg holds:
  - the usr_mode_e enum with the eight encodings above;
  - the usr_state_e enum (IDLE, RUN, DONE).
- Sub-module usr_next_value: purely combinational, taking (q, mode, si_r, si_l, pin) and producing the next q. It is shared by the single-step path and the burst path.
- The top level contains the FSM, cnt, bmode and the q register.

## Test plan
All scenarios use WIDTH=8.
1. Single-step sequence: LOAD pin=8'hA5, then SHR with si_r=0, then SHL with si_l=1 -> q goes A5, 52, A5; so_l goes 1, 0, 1.
2. Burst ROTL, amt=3, starting from q=8'h81 -> q goes 03, 06, 0C at edges k+1..k+3; done high one cycle after k+3; busy high 4 cycles.
3. Burst ASHR, amt=2, starting from q=8'h90 -> q goes C8, E4. mode toggled to CLEAR during the burst has no effect.
4. Burst edge cases:
   - amt=0 -> done after 1 cycle, q unchanged;
   - amt=15 -> clamped to 8, giving 8 ops;
   - start held high through busy -> ignored, then re-accepted the cycle after busy falls.
5. Burst SHR, amt=5, abort asserted at the 3rd RUN cycle -> exactly 2 shifts applied, busy low next cycle, done never pulsed.
6. RES pulsed low mid-burst, asynchronous to CLK -> q=0, busy=0, done=0 immediately. After release, single-step LOAD 8'h3C -> q=3C.
